// File: rtl/axi_mem_slave_if.sv
// AXI4 slave bus bundle (AW/W/B/AR/R) for the CPU-side memory responder.
// Data width is fixed at 32 bits; only ID and address widths are parameterised.
interface axi_mem_slave_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;

  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: word-addressed RAM with INCR bursts and byte strobes.
// Read and write channels are independent FSMs sharing only the RAM array.
module axi_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_ADDR_WIDTH   = 12
) (
  input  logic           ACLK,
  input  logic           ARESETN,
  axi_mem_slave_if.slave s_axi
);

  localparam int IW    = C_S_AXI_ID_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int MW    = C_MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << MW;
  localparam logic [MW-1:0] IDX_ONE = {{(MW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  logic [31:0] mem [DEPTH];

  // Holds both ready outputs low until the first clock after reset release.
  logic out_en;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic          awready_c, wready_c, bvalid_c;
  logic          arready_c, rvalid_c;
  logic          aw_fire, w_fire, ar_fire, r_fire;

  logic [IW-1:0] w_id;
  logic [MW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [7:0]    w_cnt;
  logic          w_err;
  logic          w_last_beat;

  logic [IW-1:0] r_id;
  logic [MW-1:0] r_idx;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [31:0]   rdata_q;
  logic          rlast_q;

  logic [MW-1:0] aw_idx, ar_idx;
  logic          unused_addr_bits;

  // Upper address bits alias onto the RAM; the byte offset is ignored.
  assign aw_idx = s_axi.awaddr[MW+1:2];
  assign ar_idx = s_axi.araddr[MW+1:2];
  assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.awaddr[AW-1:MW+2],
                              s_axi.araddr[1:0], s_axi.araddr[AW-1:MW+2]};

  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_en  <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      out_en  <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    bvalid_c  = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_c = out_en;
        if (out_en && s_axi.awvalid) begin
          aw_fire = 1'b1;
          w_next  = W_DATA;
        end
      end
      W_DATA: begin
        wready_c = 1'b1;
        if (s_axi.wvalid) begin
          w_fire = 1'b1;
          if (w_last_beat) begin
            w_next = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid_c = 1'b1;
        if (s_axi.bready) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Burst length is trusted over WLAST; a misplaced WLAST only flags SLVERR.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_fire) begin
      w_id  <= s_axi.awid;
      w_idx <= aw_idx;
      w_len <= s_axi.awlen;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_fire) begin
      w_idx <= w_idx + IDX_ONE;
      w_cnt <= w_cnt + 8'd1;
      if (s_axi.wlast != w_last_beat) begin
        w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    r_next    = r_state;
    arready_c = 1'b0;
    rvalid_c  = 1'b0;
    ar_fire   = 1'b0;
    r_fire    = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_c = out_en;
        if (out_en && s_axi.arvalid) begin
          ar_fire = 1'b1;
          r_next  = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_c = 1'b1;
        if (s_axi.rready) begin
          r_fire = 1'b1;
          if (rlast_q) begin
            r_next = R_IDLE;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Next beat is fetched on the accepting edge so a burst streams one beat per cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
    end else if (ar_fire) begin
      r_id    <= s_axi.arid;
      r_idx   <= ar_idx;
      r_len   <= s_axi.arlen;
      r_cnt   <= '0;
      rdata_q <= mem[ar_idx];
      rlast_q <= (s_axi.arlen == 8'd0);
    end else if (r_fire) begin
      if (rlast_q) begin
        rlast_q <= 1'b0;
      end else begin
        r_idx   <= r_idx + IDX_ONE;
        r_cnt   <= r_cnt + 8'd1;
        rdata_q <= mem[r_idx + IDX_ONE];
        rlast_q <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.bvalid  = bvalid_c;
  assign s_axi.bid     = w_id;
  assign s_axi.bresp   = w_err ? 2'b10 : 2'b00;

  assign s_axi.arready = arready_c;
  assign s_axi.rvalid  = rvalid_c;
  assign s_axi.rid     = r_id;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = 2'b00;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised bench for axi_mem_slave against a word-array memory model with
// per-scenario tasks and inline comparisons.
module tb_axi_mem_slave;

  localparam int IW    = 1;
  localparam int AW    = 32;
  localparam int MW    = 12;
  localparam int DEPTH = 1 << MW;
  localparam int TMO   = 200;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_mem_slave_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  axi_mem_slave #(
    .C_S_AXI_ID_WIDTH  (IW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_MEM_ADDR_WIDTH  (MW)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .s_axi  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]   model_mem [DEPTH];
  logic [31:0]   wr_data [256];
  logic [3:0]    wr_strb [256];
  logic          wr_last [256];
  logic [31:0]   rd_data [256];
  logic          rd_last [256];
  logic [IW-1:0] rd_id   [256];

  function automatic int word_of(logic [31:0] addr, int i);
    return (int'(addr >> 2) + i) % DEPTH;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [1:0] expected_bresp(int len);
    for (int i = 0; i <= len; i++) begin
      if (wr_last[i] != (i == len)) return 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len);
    for (int i = 0; i <= len; i++) begin
      model_mem[word_of(addr, i)] = merge(model_mem[word_of(addr, i)], wr_data[i], wr_strb[i]);
    end
  endtask

  task automatic fill_plain(input int len, input bit rand_data);
    for (int i = 0; i <= len; i++) begin
      wr_data[i] = rand_data ? $urandom : (i + 1);
      wr_strb[i] = 4'hF;
      wr_last[i] = (i == len);
    end
  endtask

  // Pure bus driver: reports what it saw, leaves judging to the scenario tasks.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [IW-1:0] id,
                          input bit gaps, output logic [1:0] resp, output logic [IW-1:0] bid_o,
                          output int b_wait, output bit tmo);
    int n;
    tmo = 0; b_wait = 0; resp = 'x; bid_o = 'x;
    @(negedge ACLK);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len[7:0]; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1) begin
      @(negedge ACLK); n++;
      if (n > TMO) begin tmo = 1; break; end
    end
    if (!tmo) @(negedge ACLK);
    bus.awvalid = 1'b0;
    if (tmo) return;
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge ACLK);
      bus.wdata = wr_data[i]; bus.wstrb = wr_strb[i]; bus.wlast = wr_last[i]; bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1) begin
        @(negedge ACLK); n++;
        if (n > TMO) begin tmo = 1; break; end
      end
      if (!tmo) @(negedge ACLK);
      bus.wvalid = 1'b0;
      if (tmo) return;
    end
    n = 0;
    while (bus.bvalid !== 1'b1) begin
      @(negedge ACLK); n++;
      if (n > TMO) begin tmo = 1; return; end
    end
    b_wait = n; resp = bus.bresp; bid_o = bus.bid;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge ACLK);
    bus.bready = 1'b1;
    @(negedge ACLK);
    bus.bready = 1'b0;
  endtask

  // mode 0: RREADY always high, 1: toggles 1,0,1,0..., 2: random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [IW-1:0] id,
                         input int mode, output int lat, output int unstable, output bit tmo,
                         output logic end_rvalid, output logic end_arready);
    int n, k, c;
    bit held;
    logic rr;
    logic [31:0] h_data;
    logic h_last;
    logic [IW-1:0] h_id;
    tmo = 0; lat = 0; unstable = 0; end_rvalid = 'x; end_arready = 'x;
    @(negedge ACLK);
    bus.arid = id; bus.araddr = addr; bus.arlen = len[7:0]; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1) begin
      @(negedge ACLK); n++;
      if (n > TMO) begin tmo = 1; break; end
    end
    if (!tmo) @(negedge ACLK);
    bus.arvalid = 1'b0;
    if (tmo) return;
    n = 0;
    while (bus.rvalid !== 1'b1) begin
      @(negedge ACLK); n++;
      if (n > TMO) begin tmo = 1; return; end
    end
    lat = n;
    k = 0; c = 0; held = 0;
    h_data = '0; h_last = 1'b0; h_id = '0;
    while (k <= len) begin
      if (held && (bus.rvalid !== 1'b1 || bus.rdata !== h_data ||
                   bus.rlast !== h_last || bus.rid !== h_id)) unstable++;
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (c % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.rready = rr;
      if (bus.rvalid === 1'b1 && rr) begin
        rd_data[k] = bus.rdata; rd_last[k] = bus.rlast; rd_id[k] = bus.rid;
        k++; held = 0;
      end else if (bus.rvalid === 1'b1) begin
        h_data = bus.rdata; h_last = bus.rlast; h_id = bus.rid; held = 1;
      end else begin
        held = 0;
      end
      @(negedge ACLK); c++;
      if (c > TMO + 4 * len) begin tmo = 1; break; end
    end
    bus.rready = 1'b0;
    end_rvalid = bus.rvalid;
    end_arready = bus.arready;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    vectors++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast});
    end
    vectors++;
    if ({bus.rdata, bus.bresp, bus.rid, bus.bid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: rdata=%h bresp=%b rid=%h bid=%h expected all zero",
               bus.rdata, bus.bresp, bus.rid, bus.bid);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    vectors++;
    if ({bus.awready, bus.arready, bus.wready} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL reset_release: aw/ar/w ready got %b expected 110",
               {bus.awready, bus.arready, bus.wready});
    end
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [IW-1:0] bid_o, id; int bw, lat, unst; bit tmo; logic erv, ear;
    id = IW'($urandom);
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    do_write(32'h10, 0, id, 0, resp, bid_o, bw, tmo);
    model_write(32'h10, 0);
    vectors++;
    if (tmo || resp !== expected_bresp(0) || bid_o !== id || bw !== 0) begin
      miscompares++;
      $display("[TB] FAIL single_write: tmo=%0d bresp=%b bid=%h bwait=%0d expected 0/%b/%h/0",
               tmo, resp, bid_o, bw, expected_bresp(0), id);
    end
    id = IW'($urandom);
    do_read(32'h10, 0, id, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || lat !== 0) begin
      miscompares++;
      $display("[TB] FAIL single_read_lat: tmo=%0d latency=%0d expected 0", tmo, lat);
    end
    vectors++;
    if (rd_data[0] !== model_mem[word_of(32'h10, 0)] || rd_last[0] !== 1'b1 || rd_id[0] !== id) begin
      miscompares++;
      $display("[TB] FAIL single_read_data: got %h last=%b id=%h expected %h last=1 id=%h",
               rd_data[0], rd_last[0], rd_id[0], model_mem[word_of(32'h10, 0)], id);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, lat, unst; bit tmo; logic erv, ear;
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    do_write(32'h20, 0, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h20, 0);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    do_write(32'h20, 0, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h20, 0);
    do_read(32'h20, 0, '0, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || rd_data[0] !== model_mem[word_of(32'h20, 0)]) begin
      miscompares++;
      $display("[TB] FAIL strobe_model: tmo=%0d got %h expected %h", tmo, rd_data[0],
               model_mem[word_of(32'h20, 0)]);
    end
    vectors++;
    if (rd_data[0] !== 32'h11BB33DD) begin
      miscompares++;
      $display("[TB] FAIL strobe_const: got %h expected 11bb33dd", rd_data[0]);
    end
  endtask

  task automatic test_burst_stall();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, lat, unst; bit tmo; logic erv, ear;
    fill_plain(3, 0);
    do_write(32'h40, 3, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h40, 3);
    do_read(32'h40, 3, '1, 1, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || unst !== 0 || erv !== 1'b0 || ear !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL burst_stall_ctrl: tmo=%0d unstable=%0d rvalid_end=%b arready_end=%b expected 0/0/0/1",
               tmo, unst, erv, ear);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_data[i] !== model_mem[word_of(32'h40, i)] || rd_last[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL burst_beat%0d: got %h last=%b expected %h last=%b", i, rd_data[i],
                 rd_last[i], model_mem[word_of(32'h40, i)], (i == 3));
      end
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, lat, unst; bit tmo; logic erv, ear;
    fill_plain(1, 1);
    wr_last[0] = 1'b1;
    do_write(32'h80, 1, '1, 0, resp, bid_o, bw, tmo);
    model_write(32'h80, 1);
    vectors++;
    if (tmo || resp !== expected_bresp(1) || resp !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL wlast_err_resp: tmo=%0d bresp=%b expected 10", tmo, resp);
    end
    do_read(32'h80, 1, '0, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || rd_data[0] !== model_mem[word_of(32'h80, 0)] || rd_data[1] !== model_mem[word_of(32'h80, 1)]) begin
      miscompares++;
      $display("[TB] FAIL wlast_err_data: got %h %h expected %h %h", rd_data[0], rd_data[1],
               model_mem[word_of(32'h80, 0)], model_mem[word_of(32'h80, 1)]);
    end
  endtask

  task automatic test_alias_wrap();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, lat, unst; bit tmo; logic erv, ear;
    wr_data[0] = 32'h0000005A; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    do_write(32'h4000, 0, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h4000, 0);
    do_read(32'h0000, 0, '0, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || rd_data[0] !== model_mem[word_of(32'h0, 0)] || rd_data[0] !== 32'h5A) begin
      miscompares++;
      $display("[TB] FAIL alias: tmo=%0d got %h expected 0000005a", tmo, rd_data[0]);
    end
    wr_data[0] = $urandom;
    do_write(32'h3FFC, 0, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h3FFC, 0);
    do_read(32'h3FFC, 1, '0, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || rd_data[0] !== model_mem[word_of(32'h3FFC, 0)] || rd_data[1] !== model_mem[word_of(32'h3FFC, 1)]
        || rd_last[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap: got %h %h last=%b expected %h %h last=1", rd_data[0], rd_data[1],
               rd_last[1], model_mem[word_of(32'h3FFC, 0)], model_mem[word_of(32'h3FFC, 1)]);
    end
  endtask

  task automatic test_read_first();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, lat, unst, n; bit tmo; logic erv, ear;
    logic [31:0] old_val;
    fill_plain(0, 1);
    do_write(32'h200, 0, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h200, 0);
    old_val = model_mem[word_of(32'h200, 0)];
    @(negedge ACLK);
    bus.awaddr = 32'h200; bus.awlen = 8'd0; bus.awid = '0; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n <= TMO) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.awvalid = 1'b0;
    wr_data[0] = ~old_val;
    bus.wdata = wr_data[0]; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h200; bus.arlen = 8'd0; bus.arvalid = 1'b1;
    vectors++;
    if ({bus.wready, bus.arready} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL rf_ready: wready/arready got %b expected 11", {bus.wready, bus.arready});
    end
    @(negedge ACLK);
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old_val) begin
      miscompares++;
      $display("[TB] FAIL read_first: rvalid=%b rdata=%h expected 1 %h", bus.rvalid, bus.rdata, old_val);
    end
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rf_bresp: bvalid=%b bresp=%b expected 1 00", bus.bvalid, bus.bresp);
    end
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge ACLK);
    bus.rready = 1'b0; bus.bready = 1'b0;
    vectors++;
    if ({bus.rvalid, bus.bvalid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rf_close: rvalid/bvalid got %b expected 00", {bus.rvalid, bus.bvalid});
    end
    wr_strb[0] = 4'hF;
    model_write(32'h200, 0);
    do_read(32'h200, 0, '0, 0, lat, unst, tmo, erv, ear);
    vectors++;
    if (tmo || rd_data[0] !== model_mem[word_of(32'h200, 0)]) begin
      miscompares++;
      $display("[TB] FAIL rf_after: got %h expected %h", rd_data[0], model_mem[word_of(32'h200, 0)]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] resp; logic [IW-1:0] bid_o; int bw, n; bit tmo, stale;
    fill_plain(3, 1);
    do_write(32'h300, 3, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h300, 3);
    @(negedge ACLK);
    bus.araddr = 32'h300; bus.arlen = 8'd3; bus.arid = '0; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n <= TMO) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== model_mem[word_of(32'h300, 0)]) begin
      miscompares++;
      $display("[TB] FAIL mid_beat0: rvalid=%b rdata=%h expected 1 %h", bus.rvalid, bus.rdata,
               model_mem[word_of(32'h300, 0)]);
    end
    @(negedge ACLK);
    bus.rready = 1'b0;
    #1 ARESETN = 1'b0;
    #1;
    vectors++;
    if ({bus.rvalid, bus.arready, bus.awready, bus.rlast} !== 4'b0 || bus.rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: rvalid/arready/awready/rlast=%b rdata=%h expected 0000 0",
               {bus.rvalid, bus.arready, bus.awready, bus.rlast}, bus.rdata);
    end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    vectors++;
    if ({bus.arready, bus.bvalid, bus.rvalid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL mid_release: arready/bvalid/rvalid got %b expected 100",
               {bus.arready, bus.bvalid, bus.rvalid});
    end
    stale = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (bus.rvalid !== 1'b0) stale = 1;
    end
    vectors++;
    if (stale) begin
      miscompares++;
      $display("[TB] FAIL mid_stale: stale R beat seen=1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    int lat, unst; bit tmo; logic erv, ear;
    for (int len = 0; len < 4; len++) begin
      do_read(32'h40, len, IW'(len), 0, lat, unst, tmo, erv, ear);
      vectors++;
      if (tmo || lat !== 0 || erv !== 1'b0 || ear !== 1'b1 || rd_last[len] !== 1'b1
          || rd_data[len] !== model_mem[word_of(32'h40, len)] || rd_id[0] !== IW'(len)) begin
        miscompares++;
        $display("[TB] FAIL b2b_len%0d: tmo=%0d lat=%0d rvalid_end=%b arready_end=%b last=%b data=%h expected 0/0/0/1/1/%h",
                 len, tmo, lat, erv, ear, rd_last[len], rd_data[len], model_mem[word_of(32'h40, len)]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [IW-1:0] bid_o, id; int bw, lat, unst, len; bit tmo; logic erv, ear;
    logic [31:0] addr;
    fill_plain(63, 1);
    do_write(32'h400, 63, '0, 0, resp, bid_o, bw, tmo);
    model_write(32'h400, 63);
    for (int t = 0; t < 30; t++) begin
      addr = 32'h400 + 32'($urandom_range(0, 56)) * 4 + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 7);
      id = IW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wr_data[i] = $urandom;
          wr_strb[i] = 4'($urandom);
          wr_last[i] = (i == len);
          if ($urandom_range(0, 15) == 0) wr_last[i] = ~wr_last[i];
        end
        do_write(addr, len, id, 1, resp, bid_o, bw, tmo);
        model_write(addr, len);
        vectors++;
        if (tmo || resp !== expected_bresp(len) || bid_o !== id) begin
          miscompares++;
          $display("[TB] FAIL rand_write%0d: tmo=%0d bresp=%b bid=%h expected 0/%b/%h",
                   t, tmo, resp, bid_o, expected_bresp(len), id);
        end
      end else begin
        do_read(addr, len, id, 2, lat, unst, tmo, erv, ear);
        vectors++;
        if (tmo || lat !== 0 || unst !== 0 || erv !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_read%0d_ctrl: tmo=%0d lat=%0d unstable=%0d rvalid_end=%b expected 0/0/0/0",
                   t, tmo, lat, unst, erv);
        end
        for (int i = 0; i <= len; i++) begin
          vectors++;
          if (rd_data[i] !== model_mem[word_of(addr, i)] || rd_last[i] !== (i == len) || rd_id[i] !== id) begin
            miscompares++;
            $display("[TB] FAIL rand_read%0d_beat%0d: got %h last=%b id=%h expected %h last=%b id=%h",
                     t, i, rd_data[i], rd_last[i], rd_id[i], model_mem[word_of(addr, i)], (i == len), id);
          end
        end
      end
    end
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_single();
    test_strobe();
    test_burst_stall();
    test_wlast_err();
    test_alias_wrap();
    test_read_first();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 memory responder (slave) serving the CPU core's instruction and data AXI master ports; one instance per port in the CPU subsystem. It holds a word-addressed internal RAM and answers single-beat and INCR burst reads and writes with byte strobes. Read and write channels run as independent state machines.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S_AXI_ADDR_WIDTH, 32, byte address width
C_MEM_ADDR_WIDTH, 12, word-address bits of the internal RAM (depth 2**C_MEM_ADDR_WIDTH x 32 bit)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWID  in  C_S_AXI_ID_WIDTH  write ID
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write start byte address
S_AXI_AWLEN  in  8  write beats minus 1
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BID  out  C_S_AXI_ID_WIDTH  response ID
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARID  in  C_S_AXI_ID_WIDTH  read ID
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read start byte address
S_AXI_ARLEN  in  8  read beats minus 1
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RID  out  C_S_AXI_ID_WIDTH  read ID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Reset (ARESETN=0, async): all outputs 0 (AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RDATA, BRESP, RID, BID); both FSMs to idle. RAM contents are not reset. Reset mid-transaction drops it; no response is issued.
- Address: word index = addr[C_MEM_ADDR_WIDTH+1:2]. addr[1:0] ignored. Upper bits ignored (aliasing). Size is always 4 bytes, burst is always INCR. Index increments by 1 per beat and wraps mod depth.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID, latch ID/index/len, set beat cnt=0, err=0, and go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes the bytes enabled by WSTRB at the current index, then index+1 and cnt+1. err is set if (WLAST != (cnt==len)). Exit to W_RESP after beat cnt==len, regardless of WLAST.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=err?2'b10:2'b00. Hold until BREADY, then W_IDLE with BVALID=0 next cycle.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake (edge T), RDATA<=mem[index], RID latched, RLAST<=(len==0). RVALID=1 from T+1 (latency 1).
  - R_DATA: RDATA, RLAST and RID stay stable while RVALID && !RREADY.
  - R handshake, not last: on the same edge RDATA<=mem[index+1] and RLAST<=(cnt+1==len). RVALID stays high, giving 1 beat/cycle.
  - R handshake with RLAST: RVALID=0 and return to R_IDLE; the next AR is accepted the following cycle.
- Same-cycle read and write to the same word: the read returns the old data (read-first).
- AW and AR are accepted in the same cycle independently; there is no ordering between channels.

Test Plan:
- AW addr 0x10 len 0, W 0xDEADBEEF strb F last=1 -> BVALID next cycle, BRESP=00; AR 0x10 -> RVALID 1 cycle after handshake, RDATA=0xDEADBEEF, RLAST=1.
- Word 0x20 = 0x11223344, write 0xAABBCCDD strb 0101 -> read 0x20 returns 0x11BB33DD.
- Preload words 0x40..0x4C = 1,2,3,4; AR len 3 with RREADY toggled 1,0,1,0 -> beats 1,2,3,4 in order, data held while stalled, RLAST only on beat 4.
- AW len 1 with WLAST=1 on beat 0 -> both beats written, BRESP=2'b10 after beat 1.
- Deassert ARESETN mid read burst (beat 2 of 4) -> RVALID/ARREADY=0 immediately; after release ARREADY=1, BVALID=0, no stale R beat.
- C_MEM_ADDR_WIDTH=12: write 0x5A at addr 0x4000 -> read at 0x0000 returns 0x5A (alias); AR at 0x3FFC len 1 -> second beat from 0x0000 (wrap).
